// File: rtl/issue_scheduler.sv
// -----------------------------------------------------------------------------
// issue_scheduler
//
// Dual-issue decode scheduler. It decides each cycle whether the two decode
// slots advance into the execute slots together, one at a time (split), or not
// at all (hazard stall). It also drives the fetch/decode stalls and the
// execute-slot bubble controls.
//
// Ports
//   clk, reset                      clock, synchronous active-high reset
//   valid_D1/D2                     decode slot holds a valid instruction
//   rs_D*/rt_D*                     decode-slot source registers
//   writeReg_D1, regWrite_D1        slot-1 destination and write enable
//   mem_D*, branch_D*               slot is load/store / decode-resolved branch
//   writeReg_E*, regWrite_E*,
//   memToReg_E*                     execute-stage producers
//   writeReg_M*, memToReg_M*        memory-stage loads
//   stall_F, stall_D                hold fetch PC and the decode pair register
//   flush_E1, flush_E2              load a bubble into the execute slot
//   issue_1, issue_2                decode slot advances into execute
//   stallCycles, splitCount         performance counters (ISSUE_PERF_CNT_EN)
//   state_dbg                       FSM state: 0 = PAIR, 1 = SECOND
//
// Optional feature: define ISSUE_PERF_CNT_EN to add the two 32-bit counters.
//
// Handshake: there is no valid/ready pair here; issue_x is the "slot x is
// accepted by execute this cycle" strobe and is purely combinational from the
// current state and inputs. stall_D=1 means the decode pair is held, so the
// same instructions are presented again next cycle.
// -----------------------------------------------------------------------------
module issue_scheduler (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_D1,
    input  logic        valid_D2,
    input  logic [4:0]  rs_D1,
    input  logic [4:0]  rt_D1,
    input  logic [4:0]  rs_D2,
    input  logic [4:0]  rt_D2,
    input  logic [4:0]  writeReg_D1,
    input  logic        regWrite_D1,
    input  logic        mem_D1,
    input  logic        mem_D2,
    input  logic        branch_D1,
    input  logic        branch_D2,
    input  logic [4:0]  writeReg_E1,
    input  logic [4:0]  writeReg_E2,
    input  logic        regWrite_E1,
    input  logic        regWrite_E2,
    input  logic        memToReg_E1,
    input  logic        memToReg_E2,
    input  logic [4:0]  writeReg_M1,
    input  logic [4:0]  writeReg_M2,
    input  logic        memToReg_M1,
    input  logic        memToReg_M2,
    output logic        stall_F,
    output logic        stall_D,
    output logic        flush_E1,
    output logic        flush_E2,
    output logic        issue_1,
    output logic        issue_2,
`ifdef ISSUE_PERF_CNT_EN
    output logic [31:0] stallCycles,
    output logic [31:0] splitCount,
`endif
    output logic        state_dbg
);

    typedef enum logic {
        PAIR   = 1'b0,
        SECOND = 1'b1
    } state_t;

    state_t state, state_next;

    // Register 0 is hardwired to zero, so it never carries a dependence.
    function automatic logic match(input logic [4:0] r, input logic [4:0] w);
        return (r == w) && (w != 5'd0);
    endfunction

    function automatic logic src_match(input logic [4:0] rs, input logic [4:0] rt,
                                       input logic [4:0] w);
        return match(rs, w) || match(rt, w);
    endfunction

    logic hz_lu_1, hz_lu_2, hz_br_1, hz_br_2, hz_1, hz_2, split;

    always_comb begin
        hz_lu_1 = valid_D1 &&
                  ((src_match(rs_D1, rt_D1, writeReg_E1) && regWrite_E1 && memToReg_E1) ||
                   (src_match(rs_D1, rt_D1, writeReg_E2) && regWrite_E2 && memToReg_E2));
        hz_lu_2 = valid_D2 &&
                  ((src_match(rs_D2, rt_D2, writeReg_E1) && regWrite_E1 && memToReg_E1) ||
                   (src_match(rs_D2, rt_D2, writeReg_E2) && regWrite_E2 && memToReg_E2));
        // Branches resolve in decode, so any in-flight ALU result in E or any
        // load still in M is not yet forwardable to the comparator.
        hz_br_1 = valid_D1 && branch_D1 &&
                  ((src_match(rs_D1, rt_D1, writeReg_E1) && regWrite_E1) ||
                   (src_match(rs_D1, rt_D1, writeReg_E2) && regWrite_E2) ||
                   (src_match(rs_D1, rt_D1, writeReg_M1) && memToReg_M1) ||
                   (src_match(rs_D1, rt_D1, writeReg_M2) && memToReg_M2));
        hz_br_2 = valid_D2 && branch_D2 &&
                  ((src_match(rs_D2, rt_D2, writeReg_E1) && regWrite_E1) ||
                   (src_match(rs_D2, rt_D2, writeReg_E2) && regWrite_E2) ||
                   (src_match(rs_D2, rt_D2, writeReg_M1) && memToReg_M1) ||
                   (src_match(rs_D2, rt_D2, writeReg_M2) && memToReg_M2));
        hz_1 = hz_lu_1 || hz_br_1;
        hz_2 = hz_lu_2 || hz_br_2;
        // A slot-2 read of slot-1's result, or two memory ops (single memory
        // port), forces the pair apart. A shared destination alone is safe
        // because the two slots retire in order.
        split = valid_D1 && valid_D2 &&
                ((regWrite_D1 && src_match(rs_D2, rt_D2, writeReg_D1)) ||
                 (mem_D1 && mem_D2));
    end

    always_ff @(posedge clk) begin
        if (reset) state <= PAIR;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        stall_F    = 1'b0;
        stall_D    = 1'b0;
        flush_E1   = 1'b0;
        flush_E2   = 1'b0;
        issue_1    = 1'b0;
        issue_2    = 1'b0;
        if (reset) begin
            flush_E1   = 1'b1;
            flush_E2   = 1'b1;
            state_next = PAIR;
        end else begin
            case (state)
                PAIR: begin
                    if (hz_1) begin
                        stall_F  = 1'b1;
                        stall_D  = 1'b1;
                        flush_E1 = 1'b1;
                        flush_E2 = 1'b1;
                    end else if (valid_D2 && (split || hz_2)) begin
                        // Issue slot 1 alone and keep the pair in decode.
                        issue_1    = 1'b1;
                        flush_E2   = 1'b1;
                        stall_F    = 1'b1;
                        stall_D    = 1'b1;
                        state_next = SECOND;
                    end else begin
                        issue_1  = valid_D1;
                        issue_2  = valid_D2;
                        flush_E1 = !valid_D1;
                        flush_E2 = !valid_D2;
                    end
                end
                SECOND: begin
                    if (hz_2) begin
                        stall_F  = 1'b1;
                        stall_D  = 1'b1;
                        flush_E1 = 1'b1;
                        flush_E2 = 1'b1;
                    end else begin
                        // Slot 1 already went; only slot 2 is released.
                        issue_2    = valid_D2;
                        flush_E1   = 1'b1;
                        flush_E2   = !valid_D2;
                        state_next = PAIR;
                    end
                end
                default: state_next = PAIR;
            endcase
        end
    end

    assign state_dbg = (state == SECOND);

`ifdef ISSUE_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stallCycles <= 32'd0;
            splitCount  <= 32'd0;
        end else begin
            if (stall_D)
                stallCycles <= stallCycles + 32'd1;
            if (state == PAIR && state_next == SECOND)
                splitCount <= splitCount + 32'd1;
        end
    end
`endif

endmodule
